// File: rtl/mac_array_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_if
// Description : Job-control, operand-beat and result handshake bundle for the
//               mac_array vector multiply-accumulate engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_array_if #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int LEN_WIDTH  = 8
);
    logic                            start;
    logic [LEN_WIDTH-1:0]            vec_len;
    logic                            signed_mode;
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_LANES*DATA_WIDTH-1:0] a_vec;
    logic [NUM_LANES*DATA_WIDTH-1:0] b_vec;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_LANES*ACC_WIDTH-1:0]  c_vec;
    logic [NUM_LANES-1:0]            sat_flag;
    logic                            busy;

    // Operand buffer / result writer side
    modport master (
        output start, vec_len, signed_mode, in_valid, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, c_vec, sat_flag, busy
    );

    // Engine side
    modport slave (
        input  start, vec_len, signed_mode, in_valid, a_vec, b_vec, out_ready,
        output in_ready, out_valid, c_vec, sat_flag, busy
    );
endinterface
`default_nettype wire

// File: rtl/mac_array.sv
`default_nettype none
// ============================================================================
// Module      : mac_array
// Description : NUM_LANES parallel saturating MAC lanes sharing one job FSM.
//               Stage 1 registers the extended lane product, stage 2 adds it
//               into a clamping accumulator with a sticky saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_array #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int LEN_WIDTH  = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mac_array_if.slave   bus
);

    localparam int PW = 2 * DATA_WIDTH;    // full product width
    localparam int EXT = ACC_WIDTH - PW + 1; // extension bits up to ACC_WIDTH+1

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 r_signed;
    logic                 r_pvld;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_busy;
    logic                 w_start_job;
    logic                 w_accept;
    logic                 w_last_beat;

    logic [NUM_LANES*ACC_WIDTH-1:0] w_c_vec;
    logic [NUM_LANES-1:0]           w_sat;

    assign w_start_job = (r_state == S_IDLE) && bus.start;
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_last_beat = w_accept && ((r_cnt + LEN_WIDTH'(1)) == r_len);

    // Next-state and handshake outputs decoded from the current state
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = (bus.vec_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus job parameters and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_pvld   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pvld  <= w_accept;
            if (w_start_job) begin
                r_len    <= bus.vec_len;
                r_signed <= bus.signed_mode;
                r_cnt    <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + LEN_WIDTH'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            logic [DATA_WIDTH-1:0]   w_a;
            logic [DATA_WIDTH-1:0]   w_b;
            logic signed [PW-1:0]    w_a_s;
            logic signed [PW-1:0]    w_b_s;
            logic [PW-1:0]           w_a_u;
            logic [PW-1:0]           w_b_u;
            logic signed [PW-1:0]    w_prod_s;
            logic [PW-1:0]           w_prod_u;
            logic [ACC_WIDTH:0]      w_prod_ext;
            logic [ACC_WIDTH:0]      r_prod;
            logic [ACC_WIDTH:0]      w_acc_ext;
            logic [ACC_WIDTH:0]      w_sum;
            logic                    w_ovf;
            logic [ACC_WIDTH-1:0]    w_clamp_val;
            logic [ACC_WIDTH-1:0]    r_acc;
            logic                    r_sat;

            assign w_a   = bus.a_vec[i*DATA_WIDTH +: DATA_WIDTH];
            assign w_b   = bus.b_vec[i*DATA_WIDTH +: DATA_WIDTH];
            assign w_a_s = {{DATA_WIDTH{w_a[DATA_WIDTH-1]}}, w_a};
            assign w_b_s = {{DATA_WIDTH{w_b[DATA_WIDTH-1]}}, w_b};
            assign w_a_u = {{DATA_WIDTH{1'b0}}, w_a};
            assign w_b_u = {{DATA_WIDTH{1'b0}}, w_b};
            assign w_prod_s = w_a_s * w_b_s;
            assign w_prod_u = w_a_u * w_b_u;

            // The product is carried one bit wider than the accumulator so the
            // adder sees both operands already in its overflow-detecting width.
            assign w_prod_ext = r_signed ? {{EXT{w_prod_s[PW-1]}}, w_prod_s}
                                         : {{EXT{1'b0}}, w_prod_u};

            assign w_acc_ext = r_signed ? {r_acc[ACC_WIDTH-1], r_acc} : {1'b0, r_acc};
            assign w_sum     = w_acc_ext + r_prod;
            assign w_ovf     = r_signed ? (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1])
                                        : w_sum[ACC_WIDTH];
            // Signed overflow direction follows the true (ACC_WIDTH+1)-bit sign
            assign w_clamp_val = !r_signed        ? {ACC_WIDTH{1'b1}} :
                                 w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};

            // Stage 1: capture the extended product of an accepted beat
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prod <= '0;
                end else if (w_accept) begin
                    r_prod <= w_prod_ext;
                end
            end

            // Stage 2: saturating accumulate with sticky overflow flag
            always_ff @(posedge clk) begin
                if (rst || w_start_job) begin
                    r_acc <= '0;
                    r_sat <= 1'b0;
                end else if (r_pvld) begin
                    if (w_ovf) begin
                        r_acc <= w_clamp_val;
                        r_sat <= 1'b1;
                    end else begin
                        r_acc <= w_sum[ACC_WIDTH-1:0];
                    end
                end
            end

            assign w_c_vec[i*ACC_WIDTH +: ACC_WIDTH] = r_acc;
            assign w_sat[i]                          = r_sat;
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.c_vec     = w_c_vec;
    assign bus.sat_flag  = w_sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_array
// Description : Directed bench for mac_array. Two instances (24-bit and 16-bit
//               accumulators) receive identical stimulus; a reference model
//               tracks job progress and clamped per-beat sums for both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  vec_len = '0;
    logic        signed_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a_vec = '0;
    logic [31:0] b_vec = '0;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_array_if #(.NUM_LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(24), .LEN_WIDTH(8)) if24 ();
    mac_array_if #(.NUM_LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)) if16 ();

    assign if24.start = start;       assign if16.start = start;
    assign if24.vec_len = vec_len;   assign if16.vec_len = vec_len;
    assign if24.signed_mode = signed_mode; assign if16.signed_mode = signed_mode;
    assign if24.in_valid = in_valid; assign if16.in_valid = in_valid;
    assign if24.a_vec = a_vec;       assign if16.a_vec = a_vec;
    assign if24.b_vec = b_vec;       assign if16.b_vec = b_vec;
    assign if24.out_ready = out_ready; assign if16.out_ready = out_ready;

    mac_array #(.NUM_LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(24), .LEN_WIDTH(8)) dut24 (
        .clk (clk),
        .rst (rst),
        .bus (if24.slave)
    );

    mac_array #(.NUM_LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit     m_init = 0;
    bit     m_busy, m_loading, m_drain, m_valid, m_signed;
    int     m_left;
    longint m_acc [2][4];
    bit     m_sat [2][4];

    function automatic int acc_w(int k);
        return (k == 0) ? 24 : 16;
    endfunction

    // One beat of one lane: exact product added, then clamped to the mode range
    function automatic longint mac_step(longint acc, logic [7:0] a, logic [7:0] b,
                                        bit sgn, int w, output bit sat);
        longint pa, pb, s, hi, lo;
        pa = sgn ? longint'($signed(a)) : longint'(a);
        pb = sgn ? longint'($signed(b)) : longint'(b);
        s  = acc + pa * pb;
        if (sgn) begin
            hi = (longint'(1) << (w - 1)) - 1;
            lo = -hi - 1;
        end else begin
            hi = (longint'(1) << w) - 1;
            lo = 0;
        end
        sat = 1'b0;
        if (s > hi) begin s = hi; sat = 1'b1; end
        if (s < lo) begin s = lo; sat = 1'b1; end
        return s;
    endfunction

    always @(posedge clk) begin : p_model
        longint nv;
        bit     s;
        if (rst) begin
            m_init <= 1; m_busy <= 0; m_loading <= 0; m_drain <= 0; m_valid <= 0;
            m_signed <= 0; m_left <= 0;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 4; i++) begin
                    m_acc[k][i] <= 0; m_sat[k][i] <= 0;
                end
        end else if (!m_busy) begin
            if (start) begin
                m_busy   <= 1;
                m_signed <= signed_mode;
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 4; i++) begin
                        m_acc[k][i] <= 0; m_sat[k][i] <= 0;
                    end
                if (vec_len == 0) m_valid <= 1;
                else begin m_loading <= 1; m_left <= int'(vec_len); end
            end
        end else if (m_loading) begin
            if (in_valid) begin
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < 4; i++) begin
                        nv = mac_step(m_acc[k][i], a_vec[i*8 +: 8], b_vec[i*8 +: 8],
                                      m_signed, acc_w(k), s);
                        m_acc[k][i] <= nv;
                        if (s) m_sat[k][i] <= 1;
                    end
                m_left <= m_left - 1;
                if (m_left == 1) begin m_loading <= 0; m_drain <= 1; end
            end
        end else if (m_drain) begin
            m_drain <= 0;
            m_valid <= 1;
        end else if (m_valid && out_ready) begin
            m_valid <= 0;
            m_busy  <= 0;
        end
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        if (m_init) begin
            check("in_ready24", if24.in_ready, m_loading);
            check("out_valid24", if24.out_valid, m_valid);
            check("busy24", if24.busy, m_busy);
            check("in_ready16", if16.in_ready, m_loading);
            check("out_valid16", if16.out_valid, m_valid);
            check("busy16", if16.busy, m_busy);
            if (m_valid || !m_busy) begin
                for (int i = 0; i < 4; i++) begin
                    check("c24", if24.c_vec[i*24 +: 24], m_acc[0][i] & 64'hFFFFFF);
                    check("sat24", if24.sat_flag[i], m_sat[0][i]);
                    check("c16", if16.c_vec[i*16 +: 16], m_acc[1][i] & 64'hFFFF);
                    check("sat16", if16.sat_flag[i], m_sat[1][i]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] lane(int idx, int val);
        logic [31:0] v;
        v = '0;
        v[idx*8 +: 8] = val[7:0];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(int len, bit sgn);
        start = 1'b1;
        vec_len = len[7:0];
        signed_mode = sgn;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(logic [31:0] a, logic [31:0] b, int gaps);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b0;
        repeat (gaps) tick();
        a_vec = a;
        b_vec = b;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            acc = if24.in_ready;
            tick();
            if (acc) break;
        end
        if (!acc) check("beat_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 50; n++) begin
            if (if24.out_valid) break;
            tick();
        end
        if (!if24.out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        tick();
        tick();
        check("rst_busy", if24.busy, 0);
        check("rst_out_valid", if24.out_valid, 0);
        check("rst_c_vec", if24.c_vec, 0);
        rst = 1'b0;

        // Unsigned dot product with exact result latency
        start_job(3, 0);
        beat(lane(0, 1), lane(0, 4), 0);
        beat(lane(0, 2), lane(0, 5), 0);
        beat(lane(0, 3), lane(0, 6), 0);
        check("lat_cycle1_valid", if24.out_valid, 0);
        check("lat_cycle1_ready", if24.in_ready, 0);
        tick();
        check("lat_cycle2_valid", if24.out_valid, 1);
        check("t1_lane0", if24.c_vec[23:0], 24'd32);
        check("t1_sat", if24.sat_flag, 0);
        take();

        // Same operands, signed then unsigned
        start_job(2, 1);
        beat(lane(1, 'hFD), lane(1, 'h07), 0);
        beat(lane(1, 'h02), lane(1, 'hFF), 0);
        wait_valid();
        check("t2_signed_lane1", if24.c_vec[47:24], 24'hFFFFE9);
        take();
        start_job(2, 0);
        beat(lane(1, 'hFD), lane(1, 'h07), 0);
        beat(lane(1, 'h02), lane(1, 'hFF), 0);
        wait_valid();
        check("t2_unsigned_lane1", if24.c_vec[47:24], 24'h0008E9);
        take();

        // Input bubbles between beats
        start_job(4, 0);
        beat(lane(0, 1), lane(0, 1), 0);
        beat(lane(0, 1), lane(0, 1), 0);
        beat(lane(0, 1), lane(0, 1), 2);
        beat(lane(0, 1), lane(0, 1), 1);
        check("t3_ready_drop", if24.in_ready, 0);
        wait_valid();
        check("t3_lane0", if24.c_vec[23:0], 24'd4);
        take();

        // Saturation on the 16-bit accumulator instance
        start_job(2, 0);
        beat(lane(0, 'hFF), lane(0, 'hFF), 0);
        beat(lane(0, 'hFF), lane(0, 'hFF), 0);
        wait_valid();
        check("t4_uns_lane0", if16.c_vec[15:0], 16'hFFFF);
        check("t4_uns_sat", if16.sat_flag[0], 1);
        check("t4_uns_no_sat24", if24.sat_flag[0], 0);
        take();
        start_job(2, 1);
        beat(lane(0, 'h80), lane(0, 'h80), 0);
        beat(lane(0, 'h80), lane(0, 'h80), 0);
        wait_valid();
        check("t4_sgn_lane0", if16.c_vec[15:0], 16'h7FFF);
        check("t4_sgn_sat", if16.sat_flag[0], 1);
        take();
        start_job(1, 0);
        check("t4_sat_cleared", if16.sat_flag[0], 0);
        beat(lane(0, 1), lane(0, 1), 0);
        wait_valid();
        take();

        // Result backpressure with an ignored start
        start_job(1, 0);
        beat(lane(2, 10), lane(2, 20), 0);
        wait_valid();
        for (int n = 0; n < 5; n++) begin
            check("t5_hold_valid", if24.out_valid, 1);
            check("t5_hold_lane2", if24.c_vec[71:48], 24'd200);
            start = (n == 2);
            vec_len = 8'd3;
            tick();
        end
        start = 1'b0;
        check("t5_still_valid", if24.out_valid, 1);
        take();
        check("t5_released_valid", if24.out_valid, 0);
        check("t5_released_busy", if24.busy, 0);

        // Zero-length job
        start_job(0, 0);
        check("t6_len0_valid", if24.out_valid, 1);
        check("t6_len0_c_vec", if24.c_vec, 0);
        take();

        // Reset in the middle of a load
        start_job(5, 0);
        beat(lane(0, 9), lane(0, 9), 0);
        beat(lane(0, 9), lane(0, 9), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_busy", if24.busy, 0);
        check("t6_rst_in_ready", if24.in_ready, 0);
        check("t6_rst_out_valid", if24.out_valid, 0);
        check("t6_rst_c_vec", if24.c_vec, 0);

        // Fresh job after reset
        start_job(2, 0);
        beat(lane(3, 3), lane(3, 5), 0);
        beat(lane(3, 4), lane(3, 6), 0);
        wait_valid();
        check("t6_fresh_lane3", if24.c_vec[95:72], 24'd39);
        take();

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
